// File: rtl/mem_responder_if.sv
// Request/response bundle between the icache/dcache pair and mem_responder.
// Signal names follow the cache request protocol.
interface mem_responder_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        busy;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iwait, iload, dwait, dload, busy
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    output iwait, iload, dwait, dload, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory serving icache and dcache requests.
// Data side wins arbitration; a grant is held until done or abandoned.
module mem_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input logic           CLK,
  input logic           RST,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          port_q;
  logic          wr_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          iwait_q;
  logic          dwait_q;
  logic [31:0]   iload_q;
  logic [31:0]   dload_q;
  logic          busy_q;

  logic [31:0] mem_q [DEPTH] = '{default: '0};

  logic d_req;
  logic held;
  logic addr_unused;

  assign d_req = bus.dREN | bus.dWEN;
  assign held  = port_q ? d_req : bus.iREN;

  assign addr_unused = ^{bus.iaddr[31:AW+2], bus.iaddr[1:0],
                         bus.daddr[31:AW+2], bus.daddr[1:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      iwait_q <= 1'b1;
      dwait_q <= 1'b1;
      iload_q <= '0;
      dload_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_req) begin
            port_q  <= 1'b1;
            wr_q    <= bus.dWEN;
            idx_q   <= bus.daddr[AW+1:2];
            wdata_q <= bus.dstore;
            cnt_q   <= 4'(LAT - 1);
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else if (bus.iREN) begin
            port_q  <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= bus.iaddr[AW+1:2];
            cnt_q   <= 4'(LAT - 1);
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Abandoned grant: back to IDLE, nothing committed.
          if (!held) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (port_q) begin
              dwait_q <= 1'b0;
              if (!wr_q) dload_q <= mem_q[idx_q];
            end else begin
              iwait_q <= 1'b0;
              iload_q <= mem_q[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          iwait_q <= 1'b1;
          dwait_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset drops state out of DONE at once, so an in-flight write is lost.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == DONE && wr_q) mem_q[idx_q] <= wdata_q;
  end

  assign bus.iwait = iwait_q;
  assign bus.iload = iload_q;
  assign bus.dwait = dwait_q;
  assign bus.dload = dload_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: stimulus queues expected wait pulses,
// a negedge monitor pops and checks them.
module tb_mem_responder;
  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_responder_if bus();

  mem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    bit          port;
    bit          rd;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(bit port, bit rd, logic [31:0] data, int at,
                      string name);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = data;
    e.cyc  = at;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic pop(bit port);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected %s pulse in cycle %0d",
               port ? "dwait" : "iwait", cyc + 1);
    end else begin
      e = sb.pop_front();
      chk({e.name, " port"}, 32'(port), 32'(e.port));
      chk({e.name, " cycle"}, cyc + 1, e.cyc);
      if (e.rd)
        chk({e.name, " data"}, port ? bus.dload : bus.iload, e.data);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.dwait === 1'b0) pop(1'b1);
      if (bus.iwait === 1'b0) pop(1'b0);
    end
  end

  // Grant lands on the next edge; wait pulse is in cycle grant+LAT+1.
  task automatic dop(bit wr, bit both, logic [31:0] a, logic [31:0] wd,
                     logic [31:0] exp, string name);
    bus.dWEN   = wr;
    bus.dREN   = !wr || both;
    bus.daddr  = a;
    bus.dstore = wd;
    push(1'b1, !wr, exp, cyc + 1 + LAT + 1, name);
    repeat (LAT + 1) step();
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    step();
  endtask

  task automatic iop(logic [31:0] a, logic [31:0] exp, string name);
    bus.iREN  = 1'b1;
    bus.iaddr = a;
    push(1'b0, 1'b1, exp, cyc + 1 + LAT + 1, name);
    repeat (LAT + 1) step();
    bus.iREN = 1'b0;
    step();
  endtask

  initial begin
    int k;
    bus.iREN   = 1'b0;
    bus.iaddr  = '0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = '0;
    bus.dstore = '0;
    step();
    step();
    RST = 1'b0;
    step();
    chk("rst iwait", 32'(bus.iwait), 32'd1);
    chk("rst dwait", 32'(bus.dwait), 32'd1);
    chk("rst iload", bus.iload, 32'h0);
    chk("rst dload", bus.dload, 32'h0);
    chk("rst busy", 32'(bus.busy), 32'd0);

    // write then read
    dop(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, "wr40");
    dop(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, "rd40");

    // contention: data first, instruction 4 cycles later
    k = cyc + 1;
    bus.iREN  = 1'b1;
    bus.iaddr = 32'h0;
    bus.dREN  = 1'b1;
    bus.daddr = 32'h40;
    push(1'b1, 1'b1, 32'hDEADBEEF, k + 3, "cont d");
    push(1'b0, 1'b1, 32'h0, k + 7, "cont i");
    step();
    chk("busy in BUSY", 32'(bus.busy), 32'd1);
    chk("iwait held", 32'(bus.iwait), 32'd1);
    repeat (2) step();
    bus.dREN = 1'b0;
    repeat (4) step();
    bus.iREN = 1'b0;
    step();
    chk("dload holds", bus.dload, 32'hDEADBEEF);

    // aliasing and alignment
    dop(1'b1, 1'b0, 32'h1003, 32'h12345678, 32'h0, "wr1003");
    dop(1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, "rd0 alias");
    iop(32'h0, 32'h12345678, "ird0 alias");

    // abort after one BUSY cycle
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h80;
    bus.dstore = 32'hAAAA5555;
    step();
    step();
    bus.dWEN = 1'b0;
    step();
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort dwait", 32'(bus.dwait), 32'd1);
    repeat (3) step();
    dop(1'b0, 1'b0, 32'h80, 32'h0, 32'h0, "rd80 after abort");

    // dREN and dWEN together act as a write
    dop(1'b1, 1'b1, 32'h20, 32'h1, 32'h0, "wr20 both");
    dop(1'b0, 1'b0, 32'h20, 32'h0, 32'h1, "rd20");

    // reset during the DONE cycle of a write
    dop(1'b1, 1'b0, 32'h10, 32'h11111111, 32'h0, "wr10");
    dop(1'b0, 1'b0, 32'h10, 32'h0, 32'h11111111, "rd10");
    bus.dWEN   = 1'b1;
    bus.daddr  = 32'h10;
    bus.dstore = 32'hFFFFFFFF;
    repeat (LAT + 1) step();
    chk("in DONE dwait", 32'(bus.dwait), 32'd0);
    RST = 1'b1;
    #1;
    chk("mid rst dwait", 32'(bus.dwait), 32'd1);
    chk("mid rst busy", 32'(bus.busy), 32'd0);
    chk("mid rst dload", bus.dload, 32'h0);
    chk("mid rst iload", bus.iload, 32'h0);
    bus.dWEN = 1'b0;
    step();
    RST = 1'b0;
    step();
    dop(1'b0, 1'b0, 32'h10, 32'h0, 32'h11111111, "rd10 after rst");

    repeat (5) step();
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
